data_memory_responder: RTL and testbench

//  Memory-side responder for the execute stage's load/store interface. Holds a

---
 rtl/data_memory_responder.sv | 101 ++++++++++
 tb/tb_data_memory_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Load/store responder: a DEPTH x 16 array with immediate stores and
// fixed-latency loads that return one valueReady pulse per readReq assertion.
module data_memory_responder #(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  memAddrLoadStore,
  input  logic [15:0] memValueStore,
  input  logic        writeReq,
  input  logic        readReq,
  output logic [15:0] memValueLoad,
  output logic        valueReady,
  output logic        busy,
  output logic        addrErr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_W  = 9'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(READ_LATENCY - 1);

  logic [15:0] mem_q [DEPTH] = '{default: 16'h0000};

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rdAddr_q, rdAddr_d;
  logic [15:0] load_q, load_d;
  logic        vr_q, vr_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        wr_in_range, rd_in_range, resp_enter;
  logic [15:0] rd_data;

  assign wr_in_range = {1'b0, memAddrLoadStore} < DEPTH_W;
  assign rd_in_range = {1'b0, rdAddr_q} < DEPTH_W;
  // cnt_q counts remaining WAIT cycles, so RESP is entered READ_LATENCY edges after accept
  assign resp_enter  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign rd_data     = rd_in_range ? mem_q[rdAddr_q[AW-1:0]] : 16'h0000;

  // Array is not reset; stores are accepted in every FSM state.
  always_ff @(posedge clk) begin
    if (writeReq && wr_in_range) mem_q[memAddrLoadStore[AW-1:0]] <= memValueStore;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdAddr_q <= 8'h00;
      load_q   <= 16'h0000;
      vr_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdAddr_q <= rdAddr_d;
      load_q   <= load_d;
      vr_q     <= vr_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdAddr_d = rdAddr_q;
    case (state_q)
      IDLE: if (readReq) begin
        state_d  = WAIT;
        cnt_d    = CNT_INIT;
        rdAddr_d = memAddrLoadStore;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      // HOLD keeps a still-asserted readReq from being serviced twice
      RESP: state_d = readReq ? HOLD : IDLE;
      HOLD: if (!readReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_d = load_q;
    vr_d   = resp_enter;
    busy_d = (state_d != IDLE);
    err_d  = (writeReq && !wr_in_range) || (resp_enter && !rd_in_range);
    if (resp_enter) load_d = rd_data;
  end

  assign memValueLoad = load_q;
  assign valueReady   = vr_q;
  assign busy         = busy_q;
  assign addrErr      = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance a (DEPTH=256, latency 2) and instance b
// (DEPTH=128, latency 1) share all inputs; expected values are hand-derived.
module tb_data_memory_responder;

  logic        clk, rst;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wr, rd;
  logic [15:0] a_load, b_load;
  logic        a_vr, a_busy, a_err, b_vr, b_busy, b_err;
  int          nvec = 0;
  int          nerr = 0;

  data_memory_responder #(.DEPTH(256), .READ_LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .memAddrLoadStore(addr), .memValueStore(wdata),
    .writeReq(wr), .readReq(rd), .memValueLoad(a_load), .valueReady(a_vr),
    .busy(a_busy), .addrErr(a_err));

  data_memory_responder #(.DEPTH(128), .READ_LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .memAddrLoadStore(addr), .memValueStore(wdata),
    .writeReq(wr), .readReq(rd), .memValueLoad(b_load), .valueReady(b_vr),
    .busy(b_busy), .addrErr(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; addr = 8'h00; wdata = 16'h0000; wr = 1'b0; rd = 1'b0;
    tick(); tick();
    chk("rst_a_vr", a_vr, 0);   chk("rst_a_busy", a_busy, 0);
    chk("rst_a_err", a_err, 0); chk("rst_a_load", a_load, 16'h0000);
    chk("rst_b_vr", b_vr, 0);   chk("rst_b_busy", b_busy, 0);
    rst = 1'b1;
    tick();

    // store BEEF @12, then hold readReq
    wr = 1; addr = 8'h12; wdata = 16'hBEEF; tick();
    wr = 0; rd = 1; tick();                       // accept edge N
    chk("ld_N_a_vr", a_vr, 0); chk("ld_N_a_busy", a_busy, 1);
    tick();                                       // N+1
    chk("ld_N1_a_vr", a_vr, 0);
    chk("ld_N1_b_vr", b_vr, 1); chk("ld_N1_b_load", b_load, 16'hBEEF);
    tick();                                       // N+2
    chk("ld_N2_a_vr", a_vr, 1); chk("ld_N2_a_load", a_load, 16'hBEEF);
    chk("ld_N2_b_vr", b_vr, 0); chk("ld_N2_b_busy", b_busy, 1);

    // held readReq: no second pulse, stays in HOLD
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_a_vr", a_vr, 0);
    end
    chk("hold_a_busy", a_busy, 1); chk("hold_a_load", a_load, 16'hBEEF);
    rd = 0; tick();
    chk("hold_exit_busy", a_busy, 0);
    rd = 1; tick();                               // re-accept M
    chk("re_M_vr", a_vr, 0);
    tick(); chk("re_M1_vr", a_vr, 0);
    tick(); chk("re_M2_vr", a_vr, 1);
    rd = 0; tick();
    chk("re_end_vr", a_vr, 0); chk("re_end_busy", a_busy, 0);

    // store during WAIT is visible; readReq dropped during WAIT
    wr = 1; addr = 8'h20; wdata = 16'h0001; tick();
    wr = 0; rd = 1; tick();                       // N
    rd = 0; wr = 1; wdata = 16'h00FF; tick();     // N+1: store in WAIT (b's RESP entry)
    chk("wait_st_b_vr", b_vr, 1); chk("wait_st_b_load", b_load, 16'h0001);
    chk("wait_st_a_vr", a_vr, 0); chk("wait_st_a_busy", a_busy, 1);
    wr = 0; tick();                               // N+2
    chk("wait_st_a_vr2", a_vr, 1); chk("wait_st_a_load", a_load, 16'h00FF);
    tick();
    chk("wait_st_a_idle", a_busy, 0); chk("wait_st_b_idle", b_busy, 0);

    // store on RESP-entry edge is not visible
    wr = 1; wdata = 16'h0001; tick();
    wr = 0; rd = 1; tick();                       // N
    rd = 0; tick();                               // N+1
    wr = 1; wdata = 16'h00FF; tick();             // N+2
    chk("same_edge_a_vr", a_vr, 1); chk("same_edge_a_load", a_load, 16'h0001);
    wr = 0; tick();

    // out-of-range on b (DEPTH=128)
    wr = 1; addr = 8'h10; wdata = 16'h5555; tick();
    addr = 8'h90; wdata = 16'h1234; tick();
    chk("oor_st_b_err", b_err, 1); chk("oor_st_a_err", a_err, 0);
    wr = 0; tick();
    chk("oor_st_b_err_end", b_err, 0);
    rd = 1; tick();                               // N
    tick();                                       // N+1
    chk("oor_ld_b_vr", b_vr, 1); chk("oor_ld_b_load", b_load, 16'h0000);
    chk("oor_ld_b_err", b_err, 1); chk("oor_ld_a_vr", a_vr, 0);
    tick();                                       // N+2
    chk("oor_ld_a_vr2", a_vr, 1); chk("oor_ld_a_load", a_load, 16'h1234);
    chk("oor_ld_a_err", a_err, 0); chk("oor_ld_b_err_end", b_err, 0);
    rd = 0; tick();
    addr = 8'h10; rd = 1; tick();                 // N
    rd = 0; tick();                               // N+1
    chk("alias_b_vr", b_vr, 1); chk("alias_b_load", b_load, 16'h5555);
    tick();
    chk("alias_a_load", a_load, 16'h5555);
    tick();
    chk("alias_a_idle", a_busy, 0);

    // reset one cycle before RESP aborts the load
    addr = 8'h12; rd = 1; tick();                 // N
    tick();                                       // N+1
    rst = 0; #1;
    chk("abort_vr", a_vr, 0); chk("abort_busy", a_busy, 0);
    chk("abort_load", a_load, 16'h0000);
    rd = 0; tick(); tick();
    rst = 1; tick();
    chk("abort_post_vr", a_vr, 0); chk("abort_post_busy", a_busy, 0);
    tick();
    chk("abort_post_vr2", a_vr, 0);

    // array survives reset
    rd = 1; tick(); tick(); tick();
    chk("keep_vr", a_vr, 1); chk("keep_load", a_load, 16'hBEEF);
    rd = 0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
